// File: rtl/axi_rd_arbiter_if.sv
// Bundle of requester-side (S_*) and downstream (M_*) AXI4 read signals seen by the arbiter.
// Every channel uses valid/ready: a beat transfers on a rising clock edge where both are 1; valid never depends on ready.
interface axi_rd_arbiter_if #(
  parameter int NUM_MST    = 4,
  parameter int ID_WIDTH   = 10,
  parameter int ADDR_WIDTH = 48,
  parameter int LEN_WIDTH  = 8,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_MST*ID_WIDTH-1:0]   S_ARID;
  logic [NUM_MST*ADDR_WIDTH-1:0] S_ARADDR;
  logic [NUM_MST*LEN_WIDTH-1:0]  S_ARLEN;
  logic [NUM_MST*3-1:0]          S_ARSIZE;
  logic [NUM_MST*2-1:0]          S_ARBURST;
  logic [NUM_MST-1:0]            S_ARVALID;
  logic [NUM_MST-1:0]            S_ARREADY;
  logic [ID_WIDTH-1:0]           S_RID;
  logic [DATA_WIDTH-1:0]         S_RDATA;
  logic [1:0]                    S_RRESP;
  logic                          S_RLAST;
  logic [NUM_MST-1:0]            S_RVALID;
  logic [NUM_MST-1:0]            S_RREADY;
  logic [ID_WIDTH-1:0]           M_ARID;
  logic [ADDR_WIDTH-1:0]         M_ARADDR;
  logic [LEN_WIDTH-1:0]          M_ARLEN;
  logic [2:0]                    M_ARSIZE;
  logic [1:0]                    M_ARBURST;
  logic                          M_ARVALID;
  logic                          M_ARREADY;
  logic [ID_WIDTH-1:0]           M_RID;
  logic [DATA_WIDTH-1:0]         M_RDATA;
  logic [1:0]                    M_RRESP;
  logic                          M_RLAST;
  logic                          M_RVALID;
  logic                          M_RREADY;
  logic                          LAST_ERR;

  // Arbiter view: it is the master of the downstream port.
  modport master (
    input  S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST, S_ARVALID, S_RREADY,
    input  M_ARREADY, M_RID, M_RDATA, M_RRESP, M_RLAST, M_RVALID,
    output S_ARREADY, S_RID, S_RDATA, S_RRESP, S_RLAST, S_RVALID,
    output M_ARID, M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST, M_ARVALID, M_RREADY, LAST_ERR
  );

  // Environment view: requesters plus the downstream slave.
  modport slave (
    output S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST, S_ARVALID, S_RREADY,
    output M_ARREADY, M_RID, M_RDATA, M_RRESP, M_RLAST, M_RVALID,
    input  S_ARREADY, S_RID, S_RDATA, S_RRESP, S_RLAST, S_RVALID,
    input  M_ARID, M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST, M_ARVALID, M_RREADY, LAST_ERR
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read port among NUM_MST requesters, one burst outstanding,
// with an RLAST-versus-ARLEN position check.
module axi_rd_arbiter #(
  parameter int NUM_MST    = 4,
  parameter int ID_WIDTH   = 10,
  parameter int ADDR_WIDTH = 48,
  parameter int LEN_WIDTH  = 8,
  parameter int DATA_WIDTH = 32,
  localparam int GW        = $clog2(NUM_MST)
) (
  input  logic          AXI_ACLK,
  input  logic          AXI_ARESET,
  axi_rd_arbiter_if.master bus,
  output logic [1:0]    state_dbg,
  output logic [GW-1:0] ptr_dbg,
  output logic [GW-1:0] grant_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

  state_t                state, state_nxt;
  logic [GW-1:0]         ptr, grant, win_idx;
  logic                  win_found;
  logic [LEN_WIDTH-1:0]  beat_cnt;
  logic [ID_WIDTH-1:0]   ar_id;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [LEN_WIDTH-1:0]  ar_len;
  logic [2:0]            ar_size;
  logic [1:0]            ar_burst;
  logic                  last_err;
  logic [NUM_MST-1:0]    s_arready, s_rvalid;
  logic                  m_rready, ar_hs, r_hs;

  // Rotating priority search starting at ptr.
  always_comb begin
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_MST; k++) begin
      cand = (int'(ptr) + k) % NUM_MST;
      if (!win_found && bus.S_ARVALID[cand]) begin
        win_found = 1'b1;
        win_idx   = GW'(cand);
      end
    end
  end

  // Reset gates the combinational handshakes so nothing transfers while it is held.
  always_comb begin
    state_nxt = state;
    s_arready = '0;
    s_rvalid  = '0;
    m_rready  = 1'b0;
    ar_hs     = 1'b0;
    r_hs      = 1'b0;
    if (!AXI_ARESET) begin
      case (state)
        IDLE: begin
          if (win_found) begin
            s_arready[win_idx] = 1'b1;
            ar_hs              = 1'b1;
            state_nxt          = ADDR;
          end
        end
        ADDR: begin
          if (bus.M_ARREADY) state_nxt = DATA;
        end
        DATA: begin
          s_rvalid[grant] = bus.M_RVALID;
          m_rready        = bus.S_RREADY[grant];
          r_hs            = bus.M_RVALID & bus.S_RREADY[grant];
          if (r_hs && bus.M_RLAST) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      state    <= IDLE;
      ptr      <= '0;
      grant    <= '0;
      beat_cnt <= '0;
      ar_id    <= '0;
      ar_addr  <= '0;
      ar_len   <= '0;
      ar_size  <= '0;
      ar_burst <= '0;
      last_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      last_err <= 1'b0;
      if (ar_hs) begin
        ar_id    <= bus.S_ARID[int'(win_idx)*ID_WIDTH +: ID_WIDTH];
        ar_addr  <= bus.S_ARADDR[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        ar_len   <= bus.S_ARLEN[int'(win_idx)*LEN_WIDTH +: LEN_WIDTH];
        ar_size  <= bus.S_ARSIZE[int'(win_idx)*3 +: 3];
        ar_burst <= bus.S_ARBURST[int'(win_idx)*2 +: 2];
        grant    <= win_idx;
        beat_cnt <= '0;
      end
      if (r_hs) begin
        if (beat_cnt != '1) beat_cnt <= beat_cnt + 1'b1;
        // beat_cnt is the zero-based index of the beat being accepted; the last one must equal ARLEN.
        last_err <= (bus.M_RLAST && (beat_cnt != ar_len)) ||
                    (!bus.M_RLAST && (beat_cnt == ar_len));
        if (bus.M_RLAST) ptr <= (grant == GW'(NUM_MST - 1)) ? '0 : grant + 1'b1;
      end
    end
  end

  assign bus.S_ARREADY = s_arready;
  assign bus.S_RVALID  = s_rvalid;
  assign bus.M_RREADY  = m_rready;
  assign bus.S_RID     = bus.M_RID;
  assign bus.S_RDATA   = bus.M_RDATA;
  assign bus.S_RRESP   = bus.M_RRESP;
  assign bus.S_RLAST   = bus.M_RLAST;
  assign bus.M_ARID    = ar_id;
  assign bus.M_ARADDR  = ar_addr;
  assign bus.M_ARLEN   = ar_len;
  assign bus.M_ARSIZE  = ar_size;
  assign bus.M_ARBURST = ar_burst;
  assign bus.M_ARVALID = (state == ADDR);
  assign bus.LAST_ERR  = last_err;
  assign state_dbg     = state;
  assign ptr_dbg       = ptr;
  assign grant_dbg     = grant;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: arbitration vector tables plus hand-written burst sequences.
module tb_axi_rd_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state_dbg, ptr_dbg, grant_dbg;
  int         total = 0;
  int         bad   = 0;
  logic [31:0] exp_q[$];

  axi_rd_arbiter_if bus ();

  axi_rd_arbiter dut (
    .AXI_ACLK  (clk),
    .AXI_ARESET(rst),
    .bus       (bus),
    .state_dbg (state_dbg),
    .ptr_dbg   (ptr_dbg),
    .grant_dbg (grant_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [3:0] arvalid;
    logic [3:0] exp_ready;
  } arb_vec_t;

  arb_vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.S_ARID = '0; bus.S_ARADDR = '0; bus.S_ARLEN = '0; bus.S_ARSIZE = '0;
    bus.S_ARBURST = '0; bus.S_ARVALID = '0; bus.S_RREADY = '0;
    bus.M_ARREADY = 1'b0; bus.M_RID = '0; bus.M_RDATA = '0; bus.M_RRESP = '0;
    bus.M_RLAST = 1'b0; bus.M_RVALID = 1'b0;
  endtask

  task automatic drive_req(input int g, input logic [9:0] id, input logic [47:0] addr,
                           input logic [7:0] len);
    bus.S_ARID[g*10 +: 10]   = id;
    bus.S_ARADDR[g*48 +: 48] = addr;
    bus.S_ARLEN[g*8 +: 8]    = len;
    bus.S_ARSIZE[g*3 +: 3]   = 3'd2;
    bus.S_ARBURST[g*2 +: 2]  = 2'd1;
    bus.S_ARVALID[g]         = 1'b1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    check("rst_state", state_dbg, 0);
    check("rst_ptr", ptr_dbg, 0);
    check("rst_m_arvalid", bus.M_ARVALID, 0);
    check("rst_m_araddr", bus.M_ARADDR, 0);
    check("rst_last_err", bus.LAST_ERR, 0);
    rst = 1'b0;
  endtask

  // Combinational arbitration only: valids are withdrawn before any clock edge.
  task automatic run_arb_table(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      bus.S_ARVALID = vecs[i].arvalid;
      #1;
      check($sformatf("arb_vec%0d", i), bus.S_ARREADY, vecs[i].exp_ready);
    end
    bus.S_ARVALID = '0;
    #1;
  endtask

  // Grant requester g from IDLE and carry the AR through ADDR into DATA.
  task automatic issue(input int g, input logic [9:0] id, input logic [47:0] addr,
                       input logic [7:0] len, input int wait_cycles);
    drive_req(g, id, addr, len);
    #1;
    check("idle_before_grant", state_dbg, 0);
    check("s_arready_grant", bus.S_ARREADY, 64'(1) << g);
    tick();
    check("m_arvalid", bus.M_ARVALID, 1);
    check("m_arid", bus.M_ARID, id);
    check("m_araddr", bus.M_ARADDR, addr);
    check("m_arlen", bus.M_ARLEN, len);
    check("grant", grant_dbg, g);
    check("addr_s_arready", bus.S_ARREADY, 0);
    for (int w = 0; w < wait_cycles; w++) begin
      tick();
      check("addr_hold_valid", bus.M_ARVALID, 1);
      check("addr_hold_araddr", bus.M_ARADDR, addr);
      check("addr_hold_arid", bus.M_ARID, id);
      check("addr_hold_s_arready", bus.S_ARREADY, 0);
    end
    bus.M_ARREADY = 1'b1;
    tick();
    bus.M_ARREADY = 1'b0;
    check("data_state", state_dbg, 2);
    check("data_m_arvalid", bus.M_ARVALID, 0);
  endtask

  // Deliver last_at+1 beats (RLAST on the final one) to granted requester g.
  task automatic run_data(input int g, input int len, input int last_at, input int stall);
    int   cnt;
    logic is_last, exp_err;
    logic [31:0] d;
    cnt = 0;
    bus.S_RREADY = 4'hF;
    if (stall > 0) begin
      bus.S_RREADY[g] = 1'b0;
      bus.M_RVALID    = 1'b1;
      bus.M_RLAST     = 1'b0;
      for (int s = 0; s < stall; s++) begin
        #1;
        check("stall_m_rready", bus.M_RREADY, 0);
        check("stall_s_rvalid", bus.S_RVALID, 64'(1) << g);
        tick();
        check("stall_last_err", bus.LAST_ERR, 0);
      end
      bus.S_RREADY[g] = 1'b1;
    end
    for (int b = 0; b <= last_at; b++) begin
      is_last = (b == last_at);
      d = 32'hD000_0000 + 32'(g << 8) + 32'(b);
      exp_q.push_back(d);
      bus.M_RDATA  = d;
      bus.M_RID    = 10'(10'h200 + g);
      bus.M_RRESP  = 2'd0;
      bus.M_RLAST  = is_last;
      bus.M_RVALID = 1'b1;
      #1;
      check("beat_s_rvalid", bus.S_RVALID, 64'(1) << g);
      check("beat_m_rready", bus.M_RREADY, 1);
      check("beat_s_rlast", bus.S_RLAST, is_last);
      check("beat_s_rid", bus.S_RID, 10'h200 + g);
      check("beat_s_rdata", bus.S_RDATA, exp_q.pop_front());
      exp_err = (is_last && cnt != len) || (!is_last && cnt == len);
      if (cnt != 255) cnt++;
      tick();
      check($sformatf("last_err_beat%0d", b), bus.LAST_ERR, exp_err);
    end
    bus.M_RVALID = 1'b0;
    bus.M_RLAST  = 1'b0;
    check("done_idle", state_dbg, 0);
    check("done_ptr", ptr_dbg, (g + 1) % 4);
  endtask

  initial begin
    int order[5];
    vecs[0] = '{4'b0000, 4'b0000};
    vecs[1] = '{4'b0001, 4'b0001};
    vecs[2] = '{4'b0110, 4'b0010};
    vecs[3] = '{4'b1000, 4'b1000};
    vecs[4] = '{4'b1100, 4'b0100};
    vecs[5] = '{4'b1111, 4'b0001};
    vecs[6] = '{4'b0001, 4'b0001};
    vecs[7] = '{4'b0110, 4'b0010};
    vecs[8] = '{4'b1001, 4'b1000};
    vecs[9] = '{4'b0100, 4'b0100};
    order   = '{0, 1, 2, 3, 0};

    apply_reset();
    run_arb_table(0, 5);

    // Single requester 2, four beats.
    issue(2, 10'h15, 48'h1000, 8'd3, 0);
    bus.S_ARVALID = '0;
    run_data(2, 3, 3, 0);

    // ptr now 3: priority search wraps.
    check("ptr_after_req2", ptr_dbg, 3);
    run_arb_table(6, 9);

    // Downstream stalls AR for 5 cycles with competing requests, then R backpressure.
    drive_req(0, 10'h001, 48'h10, 8'd0);
    drive_req(1, 10'h002, 48'h20, 8'd0);
    issue(3, 10'h2A, 48'hABCD_0000_1230, 8'd3, 5);
    bus.S_ARVALID = '0;
    run_data(3, 3, 3, 3);

    // Early RLAST: LEN=3, last on beat 2.
    issue(1, 10'h0B1, 48'h2000, 8'd3, 0);
    bus.S_ARVALID = '0;
    run_data(1, 3, 1, 0);
    tick();
    check("early_pulse_1cyc", bus.LAST_ERR, 0);
    check("early_idle", state_dbg, 0);

    // Missing RLAST: LEN=1, last arrives on beat 3.
    issue(0, 10'h0C0, 48'h3000, 8'd1, 0);
    bus.S_ARVALID = '0;
    run_data(0, 1, 2, 0);
    tick();
    check("late_pulse_clear", bus.LAST_ERR, 0);

    // All four request continuously with LEN=0 from reset.
    apply_reset();
    for (int i = 0; i < 4; i++) drive_req(i, 10'(i + 5), 48'(i * 64), 8'd0);
    for (int i = 0; i < 5; i++) begin
      issue(order[i], 10'(order[i] + 5), 48'(order[i] * 64), 8'd0, 0);
      run_data(order[i], 0, 0, 0);
    end
    bus.S_ARVALID = '0;

    // Reset in the middle of a burst.
    issue(1, 10'h0D1, 48'h4000, 8'd3, 0);
    bus.S_ARVALID = '0;
    bus.S_RREADY  = 4'hF;
    bus.M_RVALID  = 1'b1;
    bus.M_RDATA   = 32'hBAD0_0001;
    drive_req(2, 10'h0D2, 48'h5000, 8'd0);
    rst = 1'b1;
    tick();
    check("midrst_state", state_dbg, 0);
    check("midrst_ptr", ptr_dbg, 0);
    check("midrst_s_rvalid", bus.S_RVALID, 0);
    check("midrst_m_rready", bus.M_RREADY, 0);
    check("midrst_s_arready", bus.S_ARREADY, 0);
    check("midrst_m_arvalid", bus.M_ARVALID, 0);
    check("midrst_last_err", bus.LAST_ERR, 0);
    rst = 1'b0;
    clear_inputs();
    tick();
    check("postrst_idle", state_dbg, 0);
    issue(3, 10'h0E3, 48'h6000, 8'd1, 0);
    bus.S_ARVALID = '0;
    run_data(3, 1, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
